// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one async FIFO write port
// among NREQ requesters in the wclk domain. An owner is granted for a burst
// of up to BURST_MAX words, with one dead IDLE cycle between grants.
// Optional build macro FIFO_ARB_STATS_EN adds per-requester word counters
// (stat_clr / stat_cnt ports).
module fifo_wr_arbiter #(
  parameter int DSIZE      = 16,
  parameter int NREQ       = 4,
  parameter int BURST_MAX  = 8,
  parameter int ALMOST_HLD = 1
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] din,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       gnt,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  input  logic                  wfull,
  input  logic                  wfull_almost,
  output logic                  busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [NREQ*16-1:0]    stat_cnt
`endif
);

  localparam int            OW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0]    BLAST    = 8'(BURST_MAX - 1);
  localparam logic [OW-1:0] LAST_RST = OW'(NREQ - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_q, last_d;
  logic [7:0]    bcnt_q, bcnt_d;

  logic [OW-1:0] pick;
  logic          pick_vld;
  logic          grant_ok;

  // Round-robin search: first requester after the previous owner, wrapping.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!pick_vld && req[idx]) begin
        pick     = OW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // A new grant needs a requester and, when holding is enabled, FIFO headroom.
  assign grant_ok = pick_vld && !((ALMOST_HLD != 0) && wfull_almost);

  // Output decode: only an active grant drives the FIFO write port.
  always_comb begin
    gnt   = '0;
    ack   = '0;
    winc  = 1'b0;
    wdata = '0;
    busy  = 1'b0;
    if (state_q == GRANT) begin
      busy         = 1'b1;
      gnt[owner_q] = 1'b1;
      winc         = req[owner_q] & ~wfull;
      wdata        = din[int'(owner_q)*DSIZE +: DSIZE];
      if (winc) begin
        ack[owner_q] = 1'b1;
      end
    end
  end

  // Next-state: start a burst from IDLE, end it on req drop or last word.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          owner_d = pick;
          bcnt_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // wfull alone stalls: owner and bcnt hold with no timeout.
        if (!req[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (winc) begin
          bcnt_d = bcnt_q + 8'd1;
          if (bcnt_q == BLAST) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers; reset abandons any partial burst.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_q;

  // Per-requester accepted-word counters; clear takes priority over a count.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      stat_q <= '0;
    end else if (stat_clr) begin
      stat_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          stat_q[i*16 +: 16] <= stat_q[i*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a cycle-level behavioural model checks every
// output on every cycle, and directed scenarios pin it with literal values.
module tb_fifo_wr_arbiter;
  localparam int DSIZE     = 16;
  localparam int NREQ      = 4;
  localparam int BURST_MAX = 8;

  logic                  clk = 1'b0;
  logic                  wrst;
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] din;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       gnt;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  wfull;
  logic                  wfull_almost;
  logic                  busy;
`ifdef FIFO_ARB_STATS_EN
  logic                  stat_clr;
  logic [NREQ*16-1:0]    stat_cnt;
`endif

  fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST_MAX(BURST_MAX), .ALMOST_HLD(1)) dut (
    .wclk(clk), .wrst(wrst), .req(req), .din(din), .ack(ack), .gnt(gnt),
    .winc(winc), .wdata(wdata), .wfull(wfull), .wfull_almost(wfull_almost),
    .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Model state: whether a grant is active, who owns it, who owned last, words written.
  bit m_grant = 1'b0;
  int m_owner = 0;
  int m_last  = NREQ - 1;
  int m_words = 0;

  // Observed DUT history used by the directed checks.
  int          ack_own[$];
  int          ack_cyc[$];
  logic [15:0] ack_dat[$];
  int          fall_cyc[$];
  bit          prev_busy = 1'b0;
  int          ncyc = 0;

  // Compare process: predict outputs from the rules, compare, then advance the model.
  always @(negedge clk) begin
    logic [NREQ-1:0]  e_gnt, e_ack;
    logic             e_winc, e_busy;
    logic [DSIZE-1:0] e_wdata;
    int               own, j;
    ncyc++;
    e_gnt = '0; e_ack = '0; e_winc = 1'b0; e_busy = 1'b0; e_wdata = '0;
    if (!wrst && m_grant) begin
      e_busy  = 1'b1;
      e_gnt   = 4'(1 << m_owner);
      e_winc  = req[m_owner] && !wfull;
      e_ack   = e_winc ? 4'(1 << m_owner) : 4'b0;
      e_wdata = din[m_owner*DSIZE +: DSIZE];
    end
    chk("gnt", gnt, e_gnt);
    chk("ack", ack, e_ack);
    chk("winc", winc, e_winc);
    chk("wdata", wdata, e_wdata);
    chk("busy", busy, e_busy);

    if (ack != 0) begin
      own = 0;
      for (int i = 0; i < NREQ; i++) if (ack[i]) own = i;
      ack_own.push_back(own);
      ack_cyc.push_back(ncyc);
      ack_dat.push_back(wdata);
    end
    if (prev_busy && !busy) fall_cyc.push_back(ncyc);
    prev_busy = busy;

    if (wrst) begin
      m_grant = 1'b0; m_owner = 0; m_last = NREQ - 1; m_words = 0;
    end else if (!m_grant) begin
      if (req != 0 && !wfull_almost) begin
        for (int k = 1; k <= NREQ; k++) begin
          j = (m_last + k) % NREQ;
          if (req[j]) begin
            m_owner = j;
            break;
          end
        end
        m_grant = 1'b1;
        m_words = 0;
      end
    end else begin
      if (!req[m_owner]) begin
        m_grant = 1'b0;
        m_last  = m_owner;
      end else if (e_winc) begin
        m_words++;
        if (m_words == BURST_MAX) begin
          m_grant = 1'b0;
          m_last  = m_owner;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (ack_own.size() < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, (ack_own.size() >= target), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n3, first_fall;
    wrst = 1'b1; req = 4'hF; wfull = 1'b0; wfull_almost = 1'b0;
    din = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
`ifdef FIFO_ARB_STATS_EN
    stat_clr = 1'b0;
`endif

    // 1: reset holds everything quiet, first grant goes to requester 0.
    repeat (3) tick();
    #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_ack", ack, 4'b0000);
    chk("rst_winc", winc, 1'b0);
    chk("rst_busy", busy, 1'b0);
    wrst = 1'b0;
    tick();
    #1;
    chk("rst_first_gnt", gnt, 4'b0001);

    // 2: rotation with all requesters active.
    wait_acks(40, 100, "rot_timeout");
    chk("rot_own0", ack_own[0], 0);
    chk("rot_own7", ack_own[7], 0);
    chk("rot_own8", ack_own[8], 1);
    chk("rot_own16", ack_own[16], 2);
    chk("rot_own24", ack_own[24], 3);
    chk("rot_own32", ack_own[32], 0);
    chk("rot_burst_span", ack_cyc[7] - ack_cyc[0], 7);
    chk("rot_dead_cycle", ack_cyc[8] - ack_cyc[7], 2);
    chk("rot_dat8", ack_dat[8], 16'hA001);
    chk("rot_dat31", ack_dat[31], 16'hA003);
    req = 4'h0;
    repeat (2) tick();

    // 3: early release by requester 2 after three words.
    base = ack_own.size();
    din[47:32] = 16'h2000;
    req = 4'b0100;
    n3 = 0;
    for (int i = 0; i < 30 && n3 < 3; i++) begin
      tick();
      n3 = ack_own.size() - base;
      din[47:32] = 16'h2000 + 16'(n3);
    end
    req = 4'h0;
    repeat (3) tick();
    chk("early_count", ack_own.size() - base, 3);
    chk("early_own", ack_own[base], 2);
    chk("early_dat0", ack_dat[base], 16'h2000);
    chk("early_dat1", ack_dat[base+1], 16'h2001);
    chk("early_dat2", ack_dat[base+2], 16'h2002);
    req = 4'b1100;
    tick();
    #1;
    chk("early_last2_next3", gnt, 4'b1000);
    tick();
    req = 4'h0;
    repeat (2) tick();

    // 4: full stall mid-burst for requester 0.
    base = ack_own.size();
    req = 4'b0001;
    wait_acks(base + 3, 20, "stall_pre_timeout");
    wfull = 1'b1;
    repeat (3) tick();
    chk("stall_gnt_held", gnt, 4'b0001);
    chk("stall_winc", winc, 1'b0);
    repeat (2) tick();
    chk("stall_no_ack", ack_own.size() - base, 3);
    wfull = 1'b0;
    wait_acks(base + 8, 20, "stall_post_timeout");
    req = 4'h0;
    repeat (3) tick();
    chk("stall_gap", ack_cyc[base+3] - ack_cyc[base+2], 6);
    first_fall = -1;
    foreach (fall_cyc[k]) if (first_fall < 0 && fall_cyc[k] > ack_cyc[base]) first_fall = fall_cyc[k];
    chk("stall_burst_end", first_fall, ack_cyc[base+7] + 1);
    chk("stall_count", ack_own.size() - base, 8);

    // 5: almost-full holds off a new grant but never preempts one.
    wfull_almost = 1'b1;
    req = 4'b0011;
    repeat (4) begin
      tick();
      chk("almost_hold_busy", busy, 1'b0);
    end
    wfull_almost = 1'b0;
    tick();
    #1;
    chk("almost_release_gnt", gnt, 4'b0010);
    wfull_almost = 1'b1;
    base = ack_own.size();
    repeat (3) tick();
    chk("almost_no_preempt", ack_own.size() - base, 3);
    req = 4'h0;
    wfull_almost = 1'b0;
    repeat (2) tick();

    // Reset mid-burst: outputs drop at once and round-robin restarts.
    req = 4'b0110;
    repeat (3) tick();
    chk("mid_rst_pre_gnt", gnt, 4'b0100);
    wrst = 1'b1;
    #1;
    chk("mid_rst_gnt", gnt, 4'b0000);
    chk("mid_rst_winc", winc, 1'b0);
    tick();
    wrst = 1'b0;
    tick();
    #1;
    chk("mid_rst_regrant", gnt, 4'b0010);
    req = 4'h0;
    repeat (2) tick();

`ifdef FIFO_ARB_STATS_EN
    // 6: statistics counters.
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat_clr0", stat_cnt, '0);
    base = ack_own.size();
    req = 4'b0010;
    wait_acks(base + 20, 60, "stat_timeout");
    req = 4'h0;
    repeat (2) tick();
    chk("stat_cnt1", stat_cnt[31:16], 16'd20);
    chk("stat_cnt0", stat_cnt[15:0], 16'd0);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat_clr1", stat_cnt[31:16], 16'd0);
`endif

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
